// File: rtl/csr_regfile_pkg.sv
// ---------------------------------------------------------------------------
// csr_regfile_pkg
//   Shared CSR definitions used by the CSR register file and the WB stage:
//   CSR addresses, field bit positions, software-writable field masks,
//   reset values, exception codes and the masked-write helper.
// ---------------------------------------------------------------------------
package csr_regfile_pkg;

  localparam int unsigned CSR_NUM_W = 14;

  // CSR addresses
  localparam logic [CSR_NUM_W-1:0] CSR_CRMD   = 14'h000;
  localparam logic [CSR_NUM_W-1:0] CSR_PRMD   = 14'h001;
  localparam logic [CSR_NUM_W-1:0] CSR_ECFG   = 14'h004;
  localparam logic [CSR_NUM_W-1:0] CSR_ESTAT  = 14'h005;
  localparam logic [CSR_NUM_W-1:0] CSR_ERA    = 14'h006;
  localparam logic [CSR_NUM_W-1:0] CSR_BADV   = 14'h007;
  localparam logic [CSR_NUM_W-1:0] CSR_EENTRY = 14'h00C;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE0  = 14'h030;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE1  = 14'h031;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE2  = 14'h032;
  localparam logic [CSR_NUM_W-1:0] CSR_SAVE3  = 14'h033;
  localparam logic [CSR_NUM_W-1:0] CSR_TID    = 14'h040;
  localparam logic [CSR_NUM_W-1:0] CSR_TCFG   = 14'h041;
  localparam logic [CSR_NUM_W-1:0] CSR_TVAL   = 14'h042;
  localparam logic [CSR_NUM_W-1:0] CSR_TICLR  = 14'h044;

  // Field bit positions
  localparam int unsigned CRMD_PLV_LSB       = 0;   // PLV[1:0], IE at [2]
  localparam int unsigned CRMD_MODE_W        = 3;   // {IE, PLV} saved/restored as a unit
  localparam int unsigned ESTAT_IS_HW_LSB    = 2;   // IS[9:2]
  localparam int unsigned ESTAT_IS_TI        = 11;
  localparam int unsigned ESTAT_IS_IPI       = 12;
  localparam int unsigned ESTAT_IS_W         = 13;  // IS[12:0]
  localparam int unsigned ESTAT_ECODE_LSB    = 16;  // Ecode[21:16]
  localparam int unsigned ESTAT_ESUBCODE_LSB = 22;  // EsubCode[30:22]
  localparam int unsigned CRMD_IE            = 2;
  localparam int unsigned TCFG_EN            = 0;
  localparam int unsigned TCFG_PERIODIC      = 1;
  localparam int unsigned TICLR_CLR          = 0;

  // Software-writable bits per CSR
  localparam logic [31:0] WMASK_CRMD   = 32'h0000_001F;
  localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
  localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] WMASK_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] WMASK_EENTRY = 32'hFFFF_FFC0;
  localparam logic [31:0] WMASK_FULL   = 32'hFFFF_FFFF;
  localparam logic [31:0] WMASK_TICLR  = 32'h0000_0001;

  // Reset values
  localparam logic [31:0] CRMD_RESET = 32'h0000_0008;  // DA=1
  localparam logic [31:0] TVAL_STOP  = 32'hFFFF_FFFF;  // timer halted

  // Exception codes
  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0B,
    ECODE_BRK  = 6'h0C,
    ECODE_INE  = 6'h0D
  } ecode_e;

  // Bit-masked update limited to the writable field set.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                            input logic [31:0] wvalue,
                                            input logic [31:0] wmask,
                                            input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old_v & ~m) | (wvalue & m);
  endfunction

  // Exceptions that record a faulting virtual address in BADV.
  function automatic logic ecode_sets_badv(input logic [5:0] ecode);
    return (ecode == ECODE_ADEF) || (ecode == ECODE_ALE);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// ---------------------------------------------------------------------------
// csr_timer
//   Holds TCFG and TVAL and generates the timer-interrupt set request.
//   TCFG = {InitVal[31:2], Periodic[1], En[0]}. A TCFG write reloads TVAL
//   with {InitVal,2'b00}. While enabled and not halted (TVAL != all-ones),
//   TVAL counts down; at zero it fires and either reloads (periodic) or
//   halts at all-ones.
// Ports
//   clk, resetn     : clock, synchronous active-low reset
//   i_tcfg_we       : effective TCFG software write this cycle
//   i_tcfg_wdata    : masked TCFG value to store
//   o_tcfg, o_tval  : current register contents
//   o_fire          : TVAL reached zero this cycle; sets ESTAT.IS[11] next edge
// ---------------------------------------------------------------------------
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_tcfg_we,
  input  logic [31:0] i_tcfg_wdata,
  output logic [31:0] o_tcfg,
  output logic [31:0] o_tval,
  output logic        o_fire
);

  logic [31:0] r_tcfg;
  logic [31:0] r_tval;
  logic        w_running;

  assign w_running = r_tcfg[TCFG_EN] && (r_tval != TVAL_STOP);
  // A TCFG write overrides the countdown, including a would-be expiry.
  assign o_fire    = w_running && !i_tcfg_we && (r_tval == 32'h0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tcfg <= '0;
      r_tval <= TVAL_STOP;
    end else if (i_tcfg_we) begin
      r_tcfg <= i_tcfg_wdata;
      r_tval <= {i_tcfg_wdata[31:2], 2'b00};
    end else if (w_running) begin
      if (r_tval != 32'h0)
        r_tval <= r_tval - 32'h1;
      else if (r_tcfg[TCFG_PERIODIC])
        r_tval <= {r_tcfg[31:2], 2'b00};
      else
        r_tval <= TVAL_STOP;
    end
  end

  assign o_tcfg = r_tcfg;
  assign o_tval = r_tval;

endmodule

// File: rtl/csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
//   Control/status register file for the WB stage. Implements CRMD, PRMD,
//   ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0-3, TID, TCFG, TVAL and TICLR.
//   Unimplemented addresses read 0 and ignore writes.
//   Update priority each edge: reset > exception > ertn > software write.
// Ports
//   clk, resetn              : clock, synchronous active-low reset
//   csr_re, csr_num          : read qualifier and address (shared with write)
//   csr_rvalue               : combinational read data (0 when csr_re low)
//   csr_we, csr_wmask,
//   csr_wvalue               : bit-masked software write
//   wb_ex, wb_pc, wb_ecode,
//   wb_esubcode, wb_vaddr    : exception commit and its context
//   ertn_flush               : exception-return commit
//   hw_int_in, ipi_int_in    : level interrupt sources, sampled every cycle
//   ex_entry, ertn_entry     : exception and return target PCs
//   has_int                  : enabled interrupt pending
// ---------------------------------------------------------------------------
module csr_regfile
  import csr_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 csr_re,
  input  logic [CSR_NUM_W-1:0] csr_num,
  output logic [31:0]          csr_rvalue,
  input  logic                 csr_we,
  input  logic [31:0]          csr_wmask,
  input  logic [31:0]          csr_wvalue,
  input  logic                 wb_ex,
  input  logic                 ertn_flush,
  input  logic [31:0]          wb_pc,
  input  logic [5:0]           wb_ecode,
  input  logic [8:0]           wb_esubcode,
  input  logic [31:0]          wb_vaddr,
  input  logic [7:0]           hw_int_in,
  input  logic                 ipi_int_in,
  output logic [31:0]          ex_entry,
  output logic [31:0]          ertn_entry,
  output logic                 has_int
);

  logic [31:0] r_crmd;
  logic [31:0] r_prmd;
  logic [31:0] r_ecfg;
  logic [31:0] r_estat;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [31:0] r_eentry;
  logic [31:0] r_save [4];
  logic [31:0] r_tid;

  logic [31:0] w_tcfg;
  logic [31:0] w_tval;
  logic        w_timer_fire;

  logic [31:0] w_rdata;      // unqualified read data of csr_num
  logic [31:0] w_wr_fields;  // writable bits of csr_num
  logic [31:0] w_new;        // merged write value for csr_num
  logic        w_sw_we;      // software write survives priority
  logic        w_tcfg_we;
  logic        w_ticlr_clr;

  // Read mux and writable-field lookup
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_rdata     = '0;
    w_wr_fields = '0;
    case (csr_num)
      CSR_CRMD:   begin w_rdata = r_crmd;   w_wr_fields = WMASK_CRMD;   end
      CSR_PRMD:   begin w_rdata = r_prmd;   w_wr_fields = WMASK_PRMD;   end
      CSR_ECFG:   begin w_rdata = r_ecfg;   w_wr_fields = WMASK_ECFG;   end
      CSR_ESTAT:  begin w_rdata = r_estat;  w_wr_fields = WMASK_ESTAT;  end
      CSR_ERA:    begin w_rdata = r_era;    w_wr_fields = WMASK_FULL;   end
      CSR_BADV:   begin w_rdata = r_badv;   w_wr_fields = WMASK_FULL;   end
      CSR_EENTRY: begin w_rdata = r_eentry; w_wr_fields = WMASK_EENTRY; end
      CSR_SAVE0:  begin w_rdata = r_save[0]; w_wr_fields = WMASK_FULL;  end
      CSR_SAVE1:  begin w_rdata = r_save[1]; w_wr_fields = WMASK_FULL;  end
      CSR_SAVE2:  begin w_rdata = r_save[2]; w_wr_fields = WMASK_FULL;  end
      CSR_SAVE3:  begin w_rdata = r_save[3]; w_wr_fields = WMASK_FULL;  end
      CSR_TID:    begin w_rdata = r_tid;    w_wr_fields = WMASK_FULL;   end
      CSR_TCFG:   begin w_rdata = w_tcfg;   w_wr_fields = WMASK_FULL;   end
      CSR_TVAL:   begin w_rdata = w_tval;   w_wr_fields = '0;           end
      CSR_TICLR:  begin w_rdata = '0;       w_wr_fields = WMASK_TICLR;  end
      default:    begin w_rdata = '0;       w_wr_fields = '0;           end
    endcase
  end

  assign csr_rvalue = csr_re ? w_rdata : 32'h0;

  // One merge serves whichever CSR is addressed; non-writable bits keep
  // their old value. TICLR reads 0, so its merged CLR bit is wvalue&wmask.
  assign w_new       = csr_merge(w_rdata, csr_wvalue, csr_wmask, w_wr_fields);
  assign w_sw_we     = csr_we && !wb_ex && !ertn_flush;
  assign w_tcfg_we   = w_sw_we && (csr_num == CSR_TCFG);
  assign w_ticlr_clr = w_sw_we && (csr_num == CSR_TICLR) && w_new[TICLR_CLR];

  csr_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_tcfg_we    (w_tcfg_we),
    .i_tcfg_wdata (w_new),
    .o_tcfg       (w_tcfg),
    .o_tval       (w_tval),
    .o_fire       (w_timer_fire)
  );

  // Mode, exception-context registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_crmd <= CRMD_RESET;
      r_prmd <= '0;
      r_era  <= '0;
      r_badv <= '0;
    end else if (wb_ex) begin
      r_prmd[CRMD_PLV_LSB +: CRMD_MODE_W] <= r_crmd[CRMD_PLV_LSB +: CRMD_MODE_W];
      r_crmd[CRMD_PLV_LSB +: CRMD_MODE_W] <= '0;
      r_era <= wb_pc;
      if (ecode_sets_badv(wb_ecode))
        r_badv <= wb_vaddr;
    end else if (ertn_flush) begin
      r_crmd[CRMD_PLV_LSB +: CRMD_MODE_W] <= r_prmd[CRMD_PLV_LSB +: CRMD_MODE_W];
    end else if (w_sw_we) begin
      case (csr_num)
        CSR_CRMD: r_crmd <= w_new;
        CSR_PRMD: r_prmd <= w_new;
        CSR_ERA:  r_era  <= w_new;
        CSR_BADV: r_badv <= w_new;
        default:  ;
      endcase
    end
  end

  // Software-only registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ecfg   <= '0;
      r_eentry <= '0;
      r_tid    <= '0;
      // NOTE: SAVE0-3 are architectural state with defined reset values, so
      // the small array is reset entry by entry rather than left as RAM.
      for (int i = 0; i < 4; i++) r_save[i] <= '0;
    end else if (w_sw_we) begin
      case (csr_num)
        CSR_ECFG:   r_ecfg    <= w_new;
        CSR_EENTRY: r_eentry  <= w_new;
        CSR_SAVE0:  r_save[0] <= w_new;
        CSR_SAVE1:  r_save[1] <= w_new;
        CSR_SAVE2:  r_save[2] <= w_new;
        CSR_SAVE3:  r_save[3] <= w_new;
        CSR_TID:    r_tid     <= w_new;
        default:    ;
      endcase
    end
  end

  // ESTAT: interrupt status sampled every cycle, exception cause on wb_ex
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_estat <= '0;
    end else begin
      r_estat[ESTAT_IS_HW_LSB +: 8] <= hw_int_in;
      r_estat[ESTAT_IS_IPI]         <= ipi_int_in;
      // Timer expiry wins over a same-cycle TICLR clear.
      if (w_timer_fire)
        r_estat[ESTAT_IS_TI] <= 1'b1;
      else if (w_ticlr_clr)
        r_estat[ESTAT_IS_TI] <= 1'b0;
      if (wb_ex) begin
        r_estat[ESTAT_ECODE_LSB +: 6]    <= wb_ecode;
        r_estat[ESTAT_ESUBCODE_LSB +: 9] <= wb_esubcode;
      end else if (w_sw_we && (csr_num == CSR_ESTAT)) begin
        r_estat[1:0] <= w_new[1:0];
      end
    end
  end

  assign has_int    = r_crmd[CRMD_IE] &&
                      (|(r_estat[ESTAT_IS_W-1:0] & r_ecfg[ESTAT_IS_W-1:0]));
  assign ex_entry   = {r_eentry[31:6], 6'b0};
  assign ertn_entry = r_era;

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;
  import csr_regfile_pkg::*;

  logic        clk;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  int checks   = 0;
  int failures = 0;

  csr_regfile dut (
    .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_vaddr(wb_vaddr), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [13:0] num, input logic [31:0] exp);
    csr_re = 1'b1; csr_num = num;
    #1;
    check(name, csr_rvalue, exp);
  endtask

  task automatic rd_is11(input string name, input logic exp);
    csr_re = 1'b1; csr_num = CSR_ESTAT;
    #1;
    check(name, {31'b0, csr_rvalue[11]}, {31'b0, exp});
  endtask

  task automatic ex(input logic [5:0] ecode, input logic [8:0] esub,
                    input logic [31:0] pc, input logic [31:0] vaddr);
    wb_ex = 1'b1; wb_ecode = ecode; wb_esubcode = esub; wb_pc = pc; wb_vaddr = vaddr;
    tick();
    wb_ex = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0;
    csr_wvalue = '0; wb_ex = 1'b0; ertn_flush = 1'b0; wb_pc = '0; wb_ecode = '0;
    wb_esubcode = '0; wb_vaddr = '0; hw_int_in = '0; ipi_int_in = 1'b0;

    vecs[0]  = '{CSR_CRMD,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000001F};
    vecs[1]  = '{CSR_CRMD,   32'h00000003, 32'h00000000, 32'h0000001C};
    vecs[2]  = '{CSR_PRMD,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007};
    vecs[3]  = '{CSR_ECFG,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001BFF};
    vecs[4]  = '{CSR_ESTAT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
    vecs[5]  = '{CSR_ESTAT,  32'h00000001, 32'h00000000, 32'h00000002};
    vecs[6]  = '{CSR_EENTRY, 32'hFFFFFFFF, 32'h1C00807F, 32'h1C008040};
    vecs[7]  = '{CSR_SAVE0,  32'hFFFF0000, 32'hABCDEF01, 32'hABCD1111};
    vecs[8]  = '{CSR_SAVE3,  32'hFFFFFFFF, 32'h12345678, 32'h12345678};
    vecs[9]  = '{CSR_TID,    32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[10] = '{CSR_TVAL,   32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{CSR_TICLR,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{14'h010,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[13] = '{CSR_ERA,    32'hFFFFFFFF, 32'h1C000000, 32'h1C000000};
    vecs[14] = '{CSR_BADV,   32'h0F0F0000, 32'hFFFFFFFF, 32'h0F0F0000};
    vecs[15] = '{CSR_ECFG,   32'h00001BFF, 32'h00000000, 32'h00000000};
    vecs[16] = '{CSR_CRMD,   32'h00000000, 32'hFFFFFFFF, 32'h0000001C};

    // Reset state
    tick(); tick();
    resetn = 1'b1;
    rd("rst_crmd", CSR_CRMD, 32'h00000008);
    rd("rst_tval", CSR_TVAL, 32'hFFFFFFFF);
    rd("rst_estat", CSR_ESTAT, 32'h0);
    rd("rst_tcfg", CSR_TCFG, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_ertn_entry", ertn_entry, 32'h0);
    csr_re = 1'b0; csr_num = CSR_CRMD; #1;
    check("re_low_zero", csr_rvalue, 32'h0);

    // Same-cycle read returns the old value
    csr_we = 1'b1; csr_num = CSR_SAVE0; csr_wmask = '1; csr_wvalue = 32'h11111111;
    csr_re = 1'b1; #1;
    check("same_cycle_old", csr_rvalue, 32'h0);
    tick(); csr_we = 1'b0;
    rd("save0_written", CSR_SAVE0, 32'h11111111);

    // Table-driven masked writes
    for (int i = 0; i < 17; i++) begin
      wr(vecs[i].num, vecs[i].wmask, vecs[i].wvalue);
      rd($sformatf("vec%0d", i), vecs[i].num, vecs[i].exp);
    end
    check("tab_ex_entry", ex_entry, 32'h1C008040);
    rd("tab_tcfg_untouched", CSR_TCFG, 32'h0);

    // Reset overrides same-cycle write and exception
    resetn = 1'b0;
    csr_we = 1'b1; csr_num = CSR_SAVE1; csr_wmask = '1; csr_wvalue = 32'h5;
    wb_ex = 1'b1; wb_pc = 32'h1234; wb_ecode = 6'h08; wb_vaddr = 32'h99;
    tick();
    csr_we = 1'b0; wb_ex = 1'b0; resetn = 1'b1;
    rd("rst2_save0", CSR_SAVE0, 32'h0);
    rd("rst2_save1", CSR_SAVE1, 32'h0);
    rd("rst2_crmd", CSR_CRMD, 32'h00000008);
    rd("rst2_era", CSR_ERA, 32'h0);
    rd("rst2_badv", CSR_BADV, 32'h0);

    // Exception entry (SYS)
    wr(CSR_BADV, '1, 32'hAAAA0000);
    wr(CSR_EENTRY, '1, 32'h1C00807F);
    check("ex_entry", ex_entry, 32'h1C008040);
    wr(CSR_CRMD, 32'h7, 32'h7);
    rd("crmd_pre_ex", CSR_CRMD, 32'h0000000F);
    ex(6'h0B, 9'h003, 32'h1C000100, 32'h0000DEAD);
    rd("ex1_crmd", CSR_CRMD, 32'h00000008);
    rd("ex1_prmd", CSR_PRMD, 32'h00000007);
    rd("ex1_era", CSR_ERA, 32'h1C000100);
    rd("ex1_estat", CSR_ESTAT, 32'h00CB0000);
    rd("ex1_badv_kept", CSR_BADV, 32'hAAAA0000);
    check("ex1_ertn_entry", ertn_entry, 32'h1C000100);

    // ALE exception records BADV, then ERTN restores mode
    wr(CSR_CRMD, 32'h7, 32'h6);
    ex(6'h09, 9'h000, 32'h1C000100, 32'h00001003);
    rd("ex2_badv", CSR_BADV, 32'h00001003);
    rd("ex2_prmd", CSR_PRMD, 32'h00000006);
    rd("ex2_crmd", CSR_CRMD, 32'h00000008);
    rd("ex2_estat", CSR_ESTAT, 32'h00090000);
    ertn_flush = 1'b1;
    csr_we = 1'b1; csr_num = CSR_SAVE1; csr_wmask = '1; csr_wvalue = 32'h77;
    tick();
    ertn_flush = 1'b0; csr_we = 1'b0;
    rd("ertn_crmd", CSR_CRMD, 32'h0000000E);
    rd("ertn_drop_write", CSR_SAVE1, 32'h0);
    check("ertn_entry", ertn_entry, 32'h1C000100);

    // Interrupt pending
    wr(CSR_ECFG, '1, 32'h4);
    hw_int_in = 8'h01; #1;
    check("int_not_yet", {31'b0, has_int}, 32'h0);
    tick();
    check("int_pending", {31'b0, has_int}, 32'h1);
    rd("int_estat", CSR_ESTAT, 32'h00090004);
    wr(CSR_ECFG, '1, 32'h0);
    check("int_lie_off", {31'b0, has_int}, 32'h0);
    wr(CSR_ECFG, '1, 32'h4);
    check("int_lie_on", {31'b0, has_int}, 32'h1);
    wr(CSR_CRMD, 32'h4, 32'h0);
    check("int_ie_off", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h00;

    // Exception with simultaneous write: write dropped
    wb_ex = 1'b1; wb_ecode = 6'h0C; wb_esubcode = 9'h0; wb_pc = 32'h1C000200;
    csr_we = 1'b1; csr_num = CSR_SAVE2; csr_wmask = '1; csr_wvalue = 32'h1234;
    tick();
    wb_ex = 1'b0; csr_we = 1'b0;
    rd("ex_drop_write", CSR_SAVE2, 32'h0);
    rd("ex3_era", CSR_ERA, 32'h1C000200);
    ipi_int_in = 1'b1; tick(); ipi_int_in = 1'b0;
    rd("ipi_estat", CSR_ESTAT, 32'h000C1000);

    // Periodic timer
    wr(CSR_TCFG, '1, 32'h0000000B);
    rd("tcfg", CSR_TCFG, 32'h0000000B);
    rd("tval_load", CSR_TVAL, 32'h8);
    for (int k = 7; k >= 0; k--) begin
      tick();
      rd($sformatf("tval_%0d", k), CSR_TVAL, 32'(k));
    end
    rd_is11("is11_before_fire", 1'b0);
    tick();
    rd_is11("is11_fire", 1'b1);
    rd("tval_reload", CSR_TVAL, 32'h8);
    wr(CSR_TICLR, 32'h1, 32'h1);
    rd_is11("is11_cleared", 1'b0);
    rd("tval_after_clr", CSR_TVAL, 32'h7);
    for (int k = 0; k < 7; k++) tick();
    rd("tval_zero_again", CSR_TVAL, 32'h0);
    wr(CSR_TICLR, 32'h1, 32'h1);
    rd_is11("fire_beats_clr", 1'b1);
    rd("tval_reload2", CSR_TVAL, 32'h8);

    // One-shot timer
    wr(CSR_TCFG, '1, 32'h00000009);
    rd("oneshot_load", CSR_TVAL, 32'h8);
    wr(CSR_TICLR, 32'h1, 32'h1);
    for (int k = 0; k < 7; k++) tick();
    rd("oneshot_zero", CSR_TVAL, 32'h0);
    rd_is11("oneshot_pre", 1'b0);
    tick();
    rd_is11("oneshot_fire", 1'b1);
    rd("oneshot_stop", CSR_TVAL, 32'hFFFFFFFF);
    wr(CSR_TICLR, 32'h1, 32'h1);
    tick(); tick(); tick();
    rd("oneshot_hold", CSR_TVAL, 32'hFFFFFFFF);
    rd_is11("oneshot_no_refire", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
